// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with data priority and wait states
module mem_port_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, DATA_BUSY, INSTR_BUSY} state_t;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        we_q, busy, dm_elig, if_elig;
    assign busy      = state != IDLE;
    assign dm_elig   = dm_req & ~dm_ready;
    assign if_elig   = if_req & ~if_ready;
    assign mem_en    = busy;
    assign mem_we    = busy & we_q;
    assign mem_size  = busy ? size_q : 2'b00;
    assign mem_addr  = busy ? addr_q : 32'h0;
    assign mem_wdata = busy ? wdata_q : 32'h0;
    assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if_rdata <= 32'h0;
            dm_rdata <= 32'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            size_q   <= 2'b00;
            we_q     <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (dm_elig) begin
                        state   <= DATA_BUSY;
                        addr_q  <= dm_addr;
                        we_q    <= dm_we;
                        size_q  <= dm_size;
                        wdata_q <= dm_wdata;
                    end else if (if_elig) begin
                        state   <= INSTR_BUSY;
                        addr_q  <= if_addr;
                        we_q    <= 1'b0;
                        size_q  <= 2'b00;
                        wdata_q <= 32'h0;
                    end
                end
                default: begin
                    if (cnt != WS) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        state <= IDLE;
                        if (state == INSTR_BUSY) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            dm_ready <= 1'b1;
                            if (!we_q) dm_rdata <= mem_rdata;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a random run against a transaction model
module tb_mem_port_arbiter;
    logic        clk, reset;
    logic        if_req, dm_req, dm_we;
    logic [1:0]  dm_size;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall;
    logic [1:0]  mem_size;
    logic        z_if_req, z_dm_req, z_dm_we;
    logic [1:0]  z_dm_size;
    logic [31:0] z_if_addr, z_dm_addr, z_dm_wdata, z_mem_rdata;
    logic [31:0] z_if_rdata, z_dm_rdata, z_mem_addr, z_mem_wdata;
    logic        z_if_ready, z_dm_ready, z_mem_en, z_mem_we, z_stall;
    logic [1:0]  z_mem_size;
    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata),
        .if_ready(z_if_ready), .dm_req(z_dm_req), .dm_we(z_dm_we), .dm_size(z_dm_size),
        .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata), .dm_rdata(z_dm_rdata), .dm_ready(z_dm_ready),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_size(z_mem_size), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .stall(z_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        if_req;
        logic        dm_req;
        logic        dm_we;
        logic [1:0]  dm_size;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_rdata;
        logic        en;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ir;
        logic        dr;
        logic        st;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    localparam logic [31:0] D = 32'hDEADBEEF;
    localparam logic [31:0] A = 32'hA5A50001;
    localparam logic [31:0] B = 32'h0BADF00D;
    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic en, input logic we, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic ir,
                             input logic dr, input logic st, input logic [31:0] ird, input logic [31:0] drd);
        chk({tag, " mem_en"}, 32'(mem_en), 32'(en));
        chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, " mem_size"}, 32'(mem_size), 32'(size));
        chk({tag, " mem_addr"}, mem_addr, addr);
        chk({tag, " mem_wdata"}, mem_wdata, wdata);
        chk({tag, " if_ready"}, 32'(if_ready), 32'(ir));
        chk({tag, " dm_ready"}, 32'(dm_ready), 32'(dr));
        chk({tag, " stall"}, 32'(stall), 32'(st));
        chk({tag, " if_rdata"}, if_rdata, ird);
        chk({tag, " dm_rdata"}, dm_rdata, drd);
    endtask

    // transaction-level reference model state
    logic        m_busy, m_data, m_we, m_ir, m_dr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;
    int          m_left;
    logic        d_pend, i_pend;

    initial begin
        tbl[0]  = '{1'b0,1'b1,1'b0,2'b10,32'h0,32'h40,32'h0,32'h0,        1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b0,1'b1,32'h0,32'h0};
        tbl[1]  = '{1'b0,1'b1,1'b0,2'b10,32'h0,32'h40,32'h0,32'h11111111, 1'b1,1'b0,2'b10,32'h40,32'h0,       1'b0,1'b0,1'b1,32'h0,32'h0};
        tbl[2]  = '{1'b0,1'b1,1'b0,2'b10,32'h0,32'h40,32'h0,D,            1'b1,1'b0,2'b10,32'h40,32'h0,       1'b0,1'b0,1'b1,32'h0,32'h0};
        tbl[3]  = '{1'b0,1'b1,1'b0,2'b10,32'h0,32'h40,32'h0,32'h0,        1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b1,1'b0,32'h0,D};
        tbl[4]  = '{1'b0,1'b0,1'b0,2'b10,32'h0,32'h40,32'h0,32'h0,        1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b0,1'b0,32'h0,D};
        tbl[5]  = '{1'b1,1'b1,1'b0,2'b10,32'h100,32'h44,32'h0,32'h0,      1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b0,1'b1,32'h0,D};
        tbl[6]  = '{1'b1,1'b1,1'b0,2'b10,32'h100,32'h44,32'h0,32'h11111111,1'b1,1'b0,2'b10,32'h44,32'h0,      1'b0,1'b0,1'b1,32'h0,D};
        tbl[7]  = '{1'b1,1'b1,1'b0,2'b10,32'h100,32'h44,32'h0,A,          1'b1,1'b0,2'b10,32'h44,32'h0,       1'b0,1'b0,1'b1,32'h0,D};
        tbl[8]  = '{1'b1,1'b1,1'b0,2'b10,32'h100,32'h44,32'h0,32'h0,      1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b1,1'b1,32'h0,A};
        tbl[9]  = '{1'b1,1'b0,1'b0,2'b10,32'h100,32'h44,32'h0,32'h22222222,1'b1,1'b0,2'b00,32'h100,32'h0,     1'b0,1'b0,1'b1,32'h0,A};
        tbl[10] = '{1'b1,1'b0,1'b0,2'b10,32'h100,32'h44,32'h0,B,          1'b1,1'b0,2'b00,32'h100,32'h0,      1'b0,1'b0,1'b1,32'h0,A};
        tbl[11] = '{1'b1,1'b0,1'b0,2'b10,32'h100,32'h44,32'h0,32'h0,      1'b0,1'b0,2'b00,32'h0,32'h0,        1'b1,1'b0,1'b0,B,A};
        tbl[12] = '{1'b0,1'b0,1'b0,2'b10,32'h100,32'h44,32'h0,32'h0,      1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b0,1'b0,B,A};
        tbl[13] = '{1'b0,1'b1,1'b1,2'b01,32'h0,32'h80,32'h12345678,32'h0, 1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b0,1'b1,B,A};
        tbl[14] = '{1'b0,1'b1,1'b1,2'b01,32'h0,32'h80,32'h12345678,32'h0, 1'b1,1'b1,2'b01,32'h80,32'h12345678,1'b0,1'b0,1'b1,B,A};
        tbl[15] = '{1'b0,1'b1,1'b0,2'b11,32'h0,32'hFFFF0000,32'hDEAD0000,32'hFFFFFFFF,1'b1,1'b1,2'b01,32'h80,32'h12345678,1'b0,1'b0,1'b1,B,A};
        tbl[16] = '{1'b0,1'b1,1'b1,2'b01,32'h0,32'h80,32'h12345678,32'h0, 1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b1,1'b0,B,A};
        tbl[17] = '{1'b0,1'b0,1'b1,2'b01,32'h0,32'h80,32'h12345678,32'h0, 1'b0,1'b0,2'b00,32'h0,32'h0,        1'b0,1'b0,1'b0,B,A};

        {if_req, dm_req, dm_we, dm_size, if_addr, dm_addr, dm_wdata, mem_rdata} = '0;
        {z_if_req, z_dm_req, z_dm_we, z_dm_size, z_if_addr, z_dm_addr, z_dm_wdata, z_mem_rdata} = '0;
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        check_all("reset", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step();
            {if_req, dm_req, dm_we, dm_size, if_addr, dm_addr, dm_wdata, mem_rdata} =
                {tbl[i].if_req, tbl[i].dm_req, tbl[i].dm_we, tbl[i].dm_size,
                 tbl[i].if_addr, tbl[i].dm_addr, tbl[i].dm_wdata, tbl[i].mem_rdata};
            @(negedge clk);
            check_all($sformatf("row%0d", i), tbl[i].en, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata,
                      tbl[i].ir, tbl[i].dr, tbl[i].st, tbl[i].ird, tbl[i].drd);
        end

        // reset in the second busy cycle of a fetch, request kept high across it
        step(); if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b0; mem_rdata = 32'h0;
        step(); @(negedge clk); chk("rst busy1 mem_en", 32'(mem_en), 32'd1);
        step(); reset = 1'b1; @(negedge clk); chk("rst busy2 mem_en", 32'(mem_en), 32'd1);
        step(); reset = 1'b0; @(negedge clk);
        check_all("rst after", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(); mem_rdata = 32'h1; @(negedge clk);
        chk("rst regrant mem_en", 32'(mem_en), 32'd1);
        chk("rst regrant mem_addr", mem_addr, 32'h200);
        step(); mem_rdata = 32'h77665544; @(negedge clk); chk("rst regrant busy2", 32'(mem_en), 32'd1);
        step(); @(negedge clk);
        chk("rst regrant if_ready", 32'(if_ready), 32'd1);
        chk("rst regrant if_rdata", if_rdata, 32'h77665544);
        if_req = 1'b0;
        step(); @(negedge clk); chk("rst regrant pulse end", 32'(if_ready), 32'd0);

        // both requesters held high: completions must alternate data, fetch every three cycles
        step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; if_req = 1'b1; if_addr = 32'h600;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) step();
            @(negedge clk);
            chk($sformatf("alt c%0d dm_ready", c), 32'(dm_ready), 32'(c % 6 == 3));
            chk($sformatf("alt c%0d if_ready", c), 32'(if_ready), 32'(c % 6 == 0 && c > 0));
        end
        step(); dm_req = 1'b0; if_req = 1'b0;

        // zero-wait-state fetch on the second instance
        step(); z_if_req = 1'b1; z_if_addr = 32'h300; @(negedge clk);
        chk("ws0 c0 mem_en", 32'(z_mem_en), 32'd0);
        chk("ws0 c0 stall", 32'(z_stall), 32'd1);
        step(); z_mem_rdata = 32'hCAFE0000; @(negedge clk);
        chk("ws0 c1 mem_en", 32'(z_mem_en), 32'd1);
        chk("ws0 c1 mem_addr", z_mem_addr, 32'h300);
        step(); @(negedge clk);
        chk("ws0 c2 if_ready", 32'(z_if_ready), 32'd1);
        chk("ws0 c2 if_rdata", z_if_rdata, 32'hCAFE0000);
        chk("ws0 c2 mem_en", 32'(z_mem_en), 32'd0);
        z_if_req = 1'b0;
        step(); @(negedge clk); chk("ws0 c3 if_ready", 32'(z_if_ready), 32'd0);

        // randomized run against the transaction model
        step(); reset = 1'b1; {if_req, dm_req, dm_we, dm_size, if_addr, dm_addr, dm_wdata, mem_rdata} = '0;
        step(); reset = 1'b0;
        {m_busy, m_data, m_we, m_ir, m_dr, m_size, m_addr, m_wdata, m_ird, m_drd} = '0;
        m_left = 0; d_pend = 1'b0; i_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            begin
                logic nd, ni;
                nd = 1'b0; ni = 1'b0;
                if (m_busy) begin
                    if (m_left == 1) begin
                        m_busy = 1'b0;
                        if (m_data) begin
                            nd = 1'b1;
                            if (!m_we) m_drd = mem_rdata;
                        end else begin
                            ni = 1'b1;
                            m_ird = mem_rdata;
                        end
                    end else m_left--;
                end else if (dm_req && !m_dr) begin
                    {m_busy, m_data, m_left} = {1'b1, 1'b1, 32'd2};
                    {m_addr, m_we, m_size, m_wdata} = {dm_addr, dm_we, dm_size, dm_wdata};
                end else if (if_req && !m_ir) begin
                    {m_busy, m_data, m_left} = {1'b1, 1'b0, 32'd2};
                    {m_addr, m_we, m_size, m_wdata} = {if_addr, 1'b0, 2'b00, 32'h0};
                end
                m_dr = nd;
                m_ir = ni;
            end
            #1;
            mem_rdata = $urandom;
            if (d_pend && m_dr) begin
                d_pend = 1'b0;
                if ($urandom_range(1) == 1) dm_req = 1'b0;
            end else if (!d_pend) begin
                dm_we = 1'($urandom_range(1));
                dm_size = 2'($urandom_range(3));
                dm_addr = $urandom;
                dm_wdata = $urandom;
                dm_req = $urandom_range(2) != 0;
                d_pend = dm_req;
            end
            if (i_pend && m_ir) begin
                i_pend = 1'b0;
                if ($urandom_range(1) == 1) if_req = 1'b0;
            end else if (!i_pend) begin
                if_addr = $urandom;
                if_req = $urandom_range(2) != 0;
                i_pend = if_req;
            end
            @(negedge clk);
            check_all($sformatf("rand%0d", i), m_busy, m_busy & m_we, m_busy ? m_size : 2'b00,
                      m_busy ? m_addr : 32'h0, m_busy ? m_wdata : 32'h0, m_ir, m_dr,
                      (if_req & ~m_ir) | (dm_req & ~m_dr), m_ird, m_drd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
